// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: run/pause/lap/clear sequencer with 0.1 s prescaler, saturating m:ss.d time and lap freeze
module stopwatch_ctrl #(
  parameter int TICK_DIV = 10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap_reset,
  output logic [3:0] tenths,
  output logic [5:0] secs,
  output logic [3:0] mins,
  output logic       running,
  output logic       lap_active
);
  localparam int PW = $clog2(TICK_DIV);
  typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;
  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    ten_q, ten_d, min_q, min_d, lten_q, lten_d, lmin_q, lmin_d;
  logic [5:0]    sec_q, sec_d, lsec_q, lsec_d;
  logic          counting, tick, sat;
  assign counting   = (state_q == RUN) || (state_q == LAP);
  assign tick       = counting && (presc_q == PW'(TICK_DIV - 1));
  assign sat        = (ten_q == 4'd9) && (sec_q == 6'd59) && (min_q == 4'd9);
  assign running    = counting;
  assign lap_active = state_q == LAP;
  assign tenths     = lap_active ? lten_q : ten_q;
  assign secs       = lap_active ? lsec_q : sec_q;
  assign mins       = lap_active ? lmin_q : min_q;
  // next state: prescaler, carry chain, button transitions, saturation override
  always_comb begin
    state_d = state_q;
    presc_d = counting ? (tick ? '0 : presc_q + 1'b1) : presc_q;
    ten_d   = ten_q;
    sec_d   = sec_q;
    min_d   = min_q;
    lten_d  = lten_q;
    lsec_d  = lsec_q;
    lmin_d  = lmin_q;
    if (tick && !sat) begin
      if (ten_q == 4'd9) begin
        ten_d = '0;
        if (sec_q == 6'd59) begin
          sec_d = '0;
          min_d = min_q + 4'd1;
        end else sec_d = sec_q + 6'd1;
      end else ten_d = ten_q + 4'd1;
    end
    if (start_stop) state_d = counting ? PAUSE : RUN;
    else if (lap_reset) begin
      case (state_q)
        RUN: begin
          state_d = LAP;
          lten_d  = ten_q;
          lsec_d  = sec_q;
          lmin_d  = min_q;
        end
        LAP: state_d = RUN;
        PAUSE: begin
          state_d = IDLE;
          presc_d = '0;
          ten_d   = '0;
          sec_d   = '0;
          min_d   = '0;
          lten_d  = '0;
          lsec_d  = '0;
          lmin_d  = '0;
        end
        default: state_d = state_q;
      endcase
    end
    if (tick && sat) state_d = PAUSE;
  end
  // state registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      presc_q <= '0;
      ten_q   <= '0;
      sec_q   <= '0;
      min_q   <= '0;
      lten_q  <= '0;
      lsec_q  <= '0;
      lmin_q  <= '0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      ten_q   <= ten_d;
      sec_q   <= sec_d;
      min_q   <= min_d;
      lten_q  <= lten_d;
      lsec_q  <= lsec_d;
      lmin_q  <= lmin_d;
    end
  end
endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: scoreboard bench comparing the stopwatch against an integer-tenths reference model
module tb_stopwatch_ctrl;
  localparam int TD = 4;
  localparam int S_IDLE = 0, S_RUN = 1, S_LAP = 2, S_PAUSE = 3;
  logic       clk = 0, reset = 1, start_stop = 0, lap_reset = 0;
  logic [3:0] tenths, mins;
  logic [5:0] secs;
  logic       running, lap_active;
  int         checks = 0, failures = 0;
  int         m_st = S_IDLE, m_pre = 0, m_live = 0, m_lap = 0;
  logic [15:0] exp_q[$];
  event       chk_ev;

  stopwatch_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .reset(reset), .start_stop(start_stop), .lap_reset(lap_reset),
    .tenths(tenths), .secs(secs), .mins(mins), .running(running), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] expected();
    int d;
    logic [15:0] v;
    d = (m_st == S_LAP) ? m_lap : m_live;
    v = {4'(d % 10), 6'((d / 10) % 60), 4'(d / 600),
         1'(m_st == S_RUN || m_st == S_LAP), 1'(m_st == S_LAP)};
    return v;
  endfunction

  function automatic void model_reset();
    m_st = S_IDLE; m_pre = 0; m_live = 0; m_lap = 0;
  endfunction

  function automatic void model_step(logic ss, logic lr);
    bit cnt, tk, st_sat;
    cnt = (m_st == S_RUN || m_st == S_LAP);
    tk = cnt && (m_pre == TD - 1);
    st_sat = (m_live == 5999);
    if (cnt) m_pre = tk ? 0 : m_pre + 1;
    if (ss) begin
      if (tk && !st_sat) m_live++;
      m_st = cnt ? S_PAUSE : S_RUN;
    end else begin
      if (lr && m_st == S_RUN) m_lap = m_live;
      if (tk && !st_sat) m_live++;
      if (lr) begin
        if (m_st == S_RUN) m_st = S_LAP;
        else if (m_st == S_LAP) m_st = S_RUN;
        else if (m_st == S_PAUSE) begin
          m_st = S_IDLE; m_live = 0; m_lap = 0; m_pre = 0;
        end
      end
    end
    if (tk && st_sat) m_st = S_PAUSE;
  endfunction

  task automatic cyc(input logic ss, input logic lr);
    @(negedge clk);
    start_stop = ss;
    lap_reset = lr;
    @(posedge clk);
    model_step(ss, lr);
    exp_q.push_back(expected());
  endtask

  task automatic idle(input int n);
    repeat (n) cyc(0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    start_stop = 0;
    lap_reset = 0;
    #2 reset = 1;
    model_reset();
    exp_q.push_back(expected());
    -> chk_ev;
    @(negedge clk);
    reset = 0;
  endtask

  // monitor: after each edge or async event, pop expected outputs and compare
  always begin
    logic [15:0] e, a;
    @(posedge clk or chk_ev);
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {tenths, secs, mins, running, lap_active};
      checks++;
      if (a !== e) begin
        failures++;
        $display("FAIL out t=%0t got %0d:%0d.%0d run=%b lap=%b required %0d:%0d.%0d run=%b lap=%b",
                 $time, a[5:2], a[11:6], a[15:12], a[1], a[0], e[5:2], e[11:6], e[15:12], e[1], e[0]);
      end
    end
  end

  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    exp_q.push_back(expected());
    -> chk_ev;
    @(negedge clk);
    reset = 0;
    cyc(1, 0); idle(40); cyc(1, 0); idle(100);
    cyc(0, 1); cyc(0, 1); idle(5);
    cyc(1, 0); idle(20); cyc(0, 1); idle(28); cyc(0, 1); idle(10);
    cyc(1, 1); idle(5); cyc(0, 1); cyc(1, 1); idle(3);
    cyc(1, 0); cyc(0, 1); cyc(1, 0); idle(2390); cyc(0, 1); idle(40); cyc(0, 1);
    idle(24000);
    cyc(1, 0); idle(12); cyc(0, 1); cyc(1, 0);
    cyc(1, 0); idle(10); cyc(0, 1); idle(6);
    async_reset();
    idle(20); cyc(1, 0); idle(7); cyc(0, 1); idle(3);
    async_reset();
    idle(5);
    for (int i = 0; i < 4000; i++)
      cyc(1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 19) == 0));
    repeat (3) @(negedge clk);
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Sequencing controller for the stopwatch datapath: it turns one-pulse button events into a run/pause/lap/clear state machine, generates the 0.1 s count tick from the system clock, and holds the live m:ss.d time plus a frozen lap copy. It sits between the debounce/onepulse stage and the seven-segment scanner. Its `tenths`/`secs`/`mins` outputs drive the display digits directly.

## Interface
- `TICK_DIV`, default 10_000_000: clk cycles per 0.1 s tick (100 MHz clk); must be ≥ 2.
- `clk`  input  1  system clock; all state updates on its rising edge.
- `reset`  input  1  asynchronous, active-high; forces the reset state below.
- `start_stop`  input  1  single-cycle pulse: start/pause request.
- `lap_reset`  input  1  single-cycle pulse: lap (while counting) or clear (while paused).
- `tenths`  output  4  displayed tenths of a second, 0–9.
- `secs`  output  6  displayed seconds, binary 0–59.
- `mins`  output  4  displayed minutes, 0–9.
- `running`  output  1  high in RUN or LAP.
- `lap_active`  output  1  high in LAP (display frozen).

## Operation
- Reset state: IDLE; prescaler, live time, lap time and all outputs = 0.
- States:
  - IDLE: time 0:00.0.
  - RUN: counting, display live.
  - LAP: counting, display shows the lap capture.
  - PAUSE: stopped, display live.
- Transitions on a pulse:
  - IDLE: `start_stop`→RUN; `lap_reset` ignored.
  - RUN: `start_stop`→PAUSE; `lap_reset`→LAP and capture the live time into the lap register.
  - LAP: `start_stop`→PAUSE (display returns to live); `lap_reset`→RUN (release freeze).
  - PAUSE: `start_stop`→RUN; `lap_reset`→IDLE, clearing live time, lap register and prescaler.
- If both pulses arrive in the same cycle, `start_stop` wins and `lap_reset` is dropped.
- Prescaler:
  - Width `$clog2(TICK_DIV)`.
  - Increments only in RUN/LAP and holds its value in PAUSE, so the fractional tick is preserved.
  - When it equals TICK_DIV-1 it wraps to 0 and asserts an internal tick for that cycle.
- Time arithmetic on tick:
  - `tenths` 9→0 carries into `secs`.
  - `secs` 59→0 carries into `mins`.
  - All carries resolve in the same edge.
- Saturation: a tick at 9:59.9 leaves the time at 9:59.9 and forces state PAUSE (live display). No wrap to 0:00.0.
- Display mux: outputs show the lap register in LAP and the live time otherwise.

## Timing
- Pulse sampled high at edge N → new state and `running`/`lap_active` visible after edge N; lap capture happens at the same edge.
- Tick and a `start_stop` in the same RUN cycle: the increment is applied at that edge and the state becomes PAUSE. The paused value includes that tick.
- Tick in the same cycle as `lap_reset` in RUN: the lap capture takes the pre-increment live value; the live time increments.
- In LAP, the live time keeps counting, including carries and saturation; the frozen display does not change.
- First tick after IDLE→RUN occurs TICK_DIV cycles after the transition edge.
- `reset` asserted mid-count: all registers clear immediately, without waiting for a clock edge. After deassertion the block stays in IDLE until a `start_stop` pulse.

## Test plan
- TICK_DIV=4. Reset, pulse `start_stop`, wait 40 cycles → display 0:01.0, `running`=1. Pulse `start_stop` → `running`=0 and time holds for 100 cycles.
- TICK_DIV=4. Run to 0:00.5, pulse `lap_reset` → `lap_active`=1, display held at 0:00.5 while live time reaches 0:01.2. Pulse `lap_reset` → display shows live 0:01.2+.
- TICK_DIV=4. Paused at 0:02.3, pulse `lap_reset` → IDLE, outputs 0. Pulse `lap_reset` in IDLE → no change.
- TICK_DIV=4, run from 0:59.9 → next tick shows 1:00.0. Run from 9:59.8 → after two ticks 9:59.9, state PAUSE, `running`=0.
- Pulse `start_stop` and `lap_reset` in the same cycle while in RUN → PAUSE, `lap_active`=0. Same pulse pair in IDLE → RUN.
- Assert `reset` asynchronously between edges while in LAP → all outputs 0 before the next edge; 0:00.0 and IDLE after release.
